// File: rtl/rc4_stream_ctrl.sv
// rc4_stream_ctrl: sequences an external RC4 core and XORs its keystream
// with a byte stream.
//
// Flow: start -> LOAD (collect KEY_SIZE key bytes) -> CRST (one-cycle core
// reset) -> FEED (stream the key into the core) -> WAIT (first keystream
// byte) -> [DROP] -> RUN. In RUN, keystream bytes are buffered in a small
// FIFO. Each din byte is XORed with the FIFO head.
//
// Compile-time option: define RC4_DROP_EN to discard the first 256
// keystream bytes after every key schedule (RC4-drop[256]).
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   start               one-cycle pulse, begins a (re)key sequence
//   key_valid/ready/data   key byte stream, byte 0 first
//   din_valid/ready/data   plaintext/ciphertext input stream
//   dout_valid/ready/data  XOR result stream, 1-cycle latency
//   core_rst, core_key  drive the core's rst and password_input
//   core_ready, core_k  the core's output_ready and keystream byte
//   busy                high outside IDLE and RUN
//   err                 sticky keystream-overflow flag, cleared by start
//   byte_cnt            bytes delivered on dout since the last start
module rc4_stream_ctrl #(
  parameter int KEY_SIZE   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [7:0]  key_data,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [7:0]  din_data,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [7:0]  dout_data,
  output logic        core_rst,
  output logic [7:0]  core_key,
  input  logic        core_ready,
  input  logic [7:0]  core_k,
  output logic        busy,
  output logic        err,
  output logic [15:0] byte_cnt
);

  localparam int KW = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int KEY_LAST_I = KEY_SIZE - 1;
  localparam logic [KW-1:0] KIDX_LAST = KEY_LAST_I[KW-1:0];
  localparam logic [AW:0]   FIFO_FULL = FIFO_DEPTH[AW:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CRST,
    S_FEED,
    S_WAIT,
`ifdef RC4_DROP_EN
    S_DROP,
`endif
    S_RUN
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    key_mem  [KEY_SIZE];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [KW-1:0] kidx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          key_hs, din_hs, push_req, push_ok, overflow;
  logic          fifo_empty, fifo_full;

`ifdef RC4_DROP_EN
  logic [7:0] drop_cnt;
`endif

  // A key byte offered in the same cycle as start is dropped.
  assign key_ready  = (state == S_LOAD);
  assign key_hs     = key_valid & key_ready & ~start;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);

  assign din_ready  = (state == S_RUN) & ~fifo_empty & (~dout_valid | dout_ready);
  assign din_hs     = din_valid & din_ready;

  // The byte that ends WAIT belongs to the destination state.
`ifdef RC4_DROP_EN
  assign push_req = core_ready & (state == S_RUN);
`else
  assign push_req = core_ready & ((state == S_RUN) | (state == S_WAIT));
`endif
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push_ok  = push_req & (~fifo_full | din_hs);
  assign overflow = push_req & fifo_full & ~din_hs;

  assign core_rst = (state == S_IDLE) | (state == S_CRST) | start;
  assign core_key = (state == S_FEED) ? key_mem[kidx] : 8'h00;
  assign busy     = ~((state == S_IDLE) | (state == S_RUN));

  always_comb begin
    // NOTE: default first so every path assigns state_nxt; no latch.
    state_nxt = state;
    case (state)
      S_IDLE: ;
      S_LOAD: if (key_hs && kidx == KIDX_LAST) state_nxt = S_CRST;
      S_CRST: state_nxt = S_FEED;
      S_FEED: if (kidx == KIDX_LAST) state_nxt = S_WAIT;
`ifdef RC4_DROP_EN
      S_WAIT: if (core_ready) state_nxt = S_DROP;
      S_DROP: if (core_ready && drop_cnt == 8'hFF) state_nxt = S_RUN;
`else
      S_WAIT: if (core_ready) state_nxt = S_RUN;
`endif
      S_RUN:  ;
      default: state_nxt = S_IDLE;
    endcase
    if (start) state_nxt = S_LOAD;
  end

  // NOTE: non-blocking assignments for all registered state so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      kidx       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      dout_valid <= 1'b0;
      dout_data  <= 8'h00;
      err        <= 1'b0;
      byte_cnt   <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (start) begin
        kidx       <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_cnt   <= '0;
        dout_valid <= 1'b0;
        err        <= 1'b0;
        byte_cnt   <= 16'h0000;
      end else begin
        case (state)
          S_LOAD:  if (key_hs) kidx <= kidx + 1'b1;
          S_CRST:  kidx <= '0;
          S_FEED:  kidx <= (kidx == KIDX_LAST) ? '0 : kidx + 1'b1;
          default: ;
        endcase

        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (din_hs)  rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, din_hs})
          2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
          2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
          default: ;
        endcase

        if (overflow) err <= 1'b1;

        if (din_hs) begin
          dout_valid <= 1'b1;
          dout_data  <= din_data ^ fifo_mem[rd_ptr];
          byte_cnt   <= byte_cnt + 16'd1;
        end else if (dout_ready) begin
          dout_valid <= 1'b0;
        end
      end
    end
  end

`ifdef RC4_DROP_EN
  // Counts discards; the WAIT byte is discard #1, wraps to 0 on RUN entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'h00;
    end else if (start) begin
      drop_cnt <= 8'h00;
    end else if (core_ready && (state == S_WAIT || state == S_DROP)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

  // NOTE: storage arrays carry no reset; validity is tracked by kidx and
  // the FIFO pointers, and a fresh LOAD is always required after rst.
  always_ff @(posedge clk) begin
    if (key_hs) key_mem[kidx] <= key_data;
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= core_k;
  end

endmodule
